cam_capture: RTL

Upstream stage of the camera pixel FIFO: samples the camera's 8-bit parallel bus (VSYNC/HREF/D[7:0]) on the pixel clock and assembles RGB565 byte pairs into one RGB343 pixel. Each pixel is written into the FIFO with a single-cycle write strobe. The stage also provides:
- cropping to a fixed window;
- discarding of the first frames after reset, while camera configuration settles;
- per-frame start/done pulses;
- a sticky overflow flag for the downstream logic.

---
 rtl/cam_capture.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cam_capture.sv
// Camera parallel-bus capture: assembles RGB565 byte pairs into RGB343 pixels,
// crops to a fixed window, skips settling frames and flags FIFO overflow.
module cam_capture #(
  parameter int unsigned H_PIXELS    = 160,
  parameter int unsigned V_LINES     = 120,
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic                Pclk,
  input  logic                rst,
  input  logic                enable,
  input  logic                vsync,
  input  logic                href,
  input  logic [7:0]          cam_data,
  input  logic                fifo_full,
  output logic                fifo_wr,
  output logic [9:0]          fifo_data,
  output logic                frame_start,
  output logic                frame_done,
  output logic [9:0]          x_cnt,
  output logic [8:0]          y_cnt,
  output logic                overflow
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned PW = 10;
  localparam int unsigned SW = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;

  typedef enum logic [1:0] {S_SKIP, S_WAIT, S_FRAME} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   skip_cnt_q, skip_cnt_d;
  logic            vsync_q, href_q;
  logic            phase_q, phase_d;
  logic [5:0]      b0_q, b0_d;
  logic [XW-1:0]   x_cnt_q, x_cnt_d;
  logic [YW-1:0]   y_cnt_q, y_cnt_d;
  logic            fifo_wr_q, fifo_wr_d;
  logic [PW-1:0]   fifo_data_q, fifo_data_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_done_q, frame_done_d;
  logic            overflow_q, overflow_d;

  logic            vs_fall_c, vs_rise_c, href_fall_c, in_window_c;
  logic [PW-1:0]   pix_c;

  assign vs_fall_c   = ~vsync & vsync_q;
  assign vs_rise_c   = vsync & ~vsync_q;
  assign href_fall_c = ~href & href_q;
  assign in_window_c = (32'(x_cnt_q) < H_PIXELS) && (32'(y_cnt_q) < V_LINES);
  // b0 keeps only the R[4:2] and G[5:3] bits of the first byte
  assign pix_c       = {b0_q, cam_data[7], cam_data[4:2]};

  always_comb begin
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    phase_d       = phase_q;
    b0_d          = b0_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    fifo_wr_d     = 1'b0;
    fifo_data_d   = fifo_data_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    overflow_d    = overflow_q;
    unique case (state_q)
      S_SKIP: begin
        if (SKIP_FRAMES == 0) begin
          state_d = S_WAIT;
        end else if (vs_rise_c) begin
          if (skip_cnt_q == SW'(SKIP_FRAMES - 1)) state_d = S_WAIT;
          else skip_cnt_d = skip_cnt_q + SW'(1);
        end
      end
      S_WAIT: begin
        if (vs_fall_c && enable) begin
          state_d       = S_FRAME;
          frame_start_d = 1'b1;
          x_cnt_d       = '0;
          y_cnt_d       = '0;
          phase_d       = 1'b0;
        end
      end
      S_FRAME: begin
        // a frame end aborts any line in progress
        if (vs_rise_c) begin
          frame_done_d = 1'b1;
          state_d      = S_WAIT;
        end else if (href_fall_c) begin
          y_cnt_d = (y_cnt_q == '1) ? y_cnt_q : y_cnt_q + YW'(1);
          x_cnt_d = '0;
          phase_d = 1'b0;
        end else if (href) begin
          if (!phase_q) begin
            b0_d    = {cam_data[7:5], cam_data[2:0]};
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            x_cnt_d = (x_cnt_q == '1) ? x_cnt_q : x_cnt_q + XW'(1);
            if (in_window_c) begin
              if (fifo_full) begin
                overflow_d = 1'b1;
              end else begin
                fifo_wr_d   = 1'b1;
                fifo_data_d = pix_c;
              end
            end
          end
        end
      end
      default: state_d = S_SKIP;
    endcase
  end

  always_ff @(posedge Pclk) begin
    if (rst) begin
      state_q       <= S_SKIP;
      skip_cnt_q    <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      phase_q       <= 1'b0;
      b0_q          <= '0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      fifo_wr_q     <= 1'b0;
      fifo_data_q   <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      vsync_q       <= vsync;
      href_q        <= href;
      phase_q       <= phase_d;
      b0_q          <= b0_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_data_q   <= fifo_data_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
    end
  end

  assign fifo_wr     = fifo_wr_q;
  assign fifo_data   = fifo_data_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign x_cnt       = x_cnt_q;
  assign y_cnt       = y_cnt_q;
  assign overflow    = overflow_q;

endmodule
